// File: rtl/mul_sequencer.sv
// Sequences a fixed-latency 32x32 multiplier on behalf of the processor control unit and owns HI/LO.
// Build option: define MUL_QUEUE_EN to add a one-entry pending request buffer.
module mul_sequencer #(
  parameter int unsigned LATENCY = 18,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_s,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  input  logic        rd_en,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_stall
);

  typedef enum logic [1:0] {FLUSH, IDLE, START, WAIT} state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  logic        accept;
  logic        capture;
  logic        load_req;
  logic        push;
  logic        pop;
  logic        pend_valid;
  logic        pend_valid_d;
  logic        pend_signed;
  logic [31:0] pend_a;
  logic [31:0] pend_b;
  logic        req_ready_d;
  logic        busy_d;
  logic        mul_start_d;

  assign accept  = req && req_ready;
  assign capture = (state == WAIT) && (cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FLUSH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a buffered request relaunches straight from WAIT
  always_comb begin
    next_state = state;
    case (state)
      FLUSH:   if (cnt <= CNT_W'(1)) next_state = IDLE;
      IDLE:    if (accept || pend_valid) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (capture) next_state = pend_valid ? START : IDLE;
      default: next_state = FLUSH;
    endcase
  end

  // Output / datapath control; output registers are loaded with next-cycle values
  always_comb begin
    cnt_d    = cnt;
    load_req = 1'b0;
    pop      = 1'b0;
    case (state)
      FLUSH: begin
        if (cnt != '0) cnt_d = cnt - CNT_W'(1);
      end
      IDLE: begin
        load_req = accept && !pend_valid;
        pop      = pend_valid;
      end
      START: begin
        cnt_d = CNT_W'(LATENCY - 1);
      end
      WAIT: begin
        if (cnt != '0) cnt_d = cnt - CNT_W'(1);
        pop = capture && pend_valid;
      end
      default: begin
        cnt_d = CNT_W'(LATENCY);
      end
    endcase
`ifdef MUL_QUEUE_EN
    push         = accept && ((state == START) || (state == WAIT));
    pend_valid_d = (pend_valid && !pop) || push;
    req_ready_d  = (next_state != FLUSH) && !pend_valid_d;
`else
    push         = 1'b0;
    pend_valid_d = pend_valid && !pop;
    req_ready_d  = (next_state == IDLE);
`endif
    busy_d      = (next_state != IDLE) || pend_valid_d;
    mul_start_d = (next_state == START);
  end

  // Registered outputs, operand registers and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= CNT_W'(LATENCY);
      req_ready  <= 1'b0;
      busy       <= 1'b1;
      mul_start  <= 1'b0;
      done       <= 1'b0;
      mul_signed <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      cnt       <= cnt_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
      mul_start <= mul_start_d;
      done      <= capture;
      if (load_req) begin
        mul_signed <= req_signed;
        mul_a      <= req_a;
        mul_b      <= req_b;
      end else if (pop) begin
        mul_signed <= pend_signed;
        mul_a      <= pend_a;
        mul_b      <= pend_b;
      end
      if (capture) begin
        hi <= mul_s[63:32];
        lo <= mul_s[31:0];
      end
    end
  end

`ifdef MUL_QUEUE_EN
  // One-entry pending buffer filled while an operation is in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      pend_signed <= 1'b0;
      pend_a      <= '0;
      pend_b      <= '0;
    end else begin
      pend_valid <= pend_valid_d;
      if (push) begin
        pend_signed <= req_signed;
        pend_a      <= req_a;
        pend_b      <= req_b;
      end
    end
  end
`else
  assign pend_valid  = 1'b0;
  assign pend_signed = 1'b0;
  assign pend_a      = '0;
  assign pend_b      = '0;
`endif

  // mfhi/mflo read port; stale value is returned while stalled
  assign rd_data  = rd_sel ? hi : lo;
  assign rd_stall = rd_en && busy;

endmodule
